// File: rtl/max_pool_bram_acc.sv
// Dual-port feature-map buffer. Port A does plain byte-enabled reads and writes; port B adds a per-lane
// max-accumulate read-modify-write. Read latency is 1+OUT_REG. An accumulate commits one cycle after its request. There are no stalls.
module max_pool_bram_acc #(
  parameter int DATA_W      = 32,
  parameter int LANE_W      = 8,
  parameter bit LANE_SIGNED = 1'b1,
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 32,
  parameter bit OUT_REG     = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                a_en,
  input  logic [DATA_W/8-1:0] a_we,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_din,
  output logic [DATA_W-1:0]   a_dout,
  input  logic                b_en,
  input  logic [DATA_W/8-1:0] b_we,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_din,
  input  logic                b_acc,
  output logic [DATA_W-1:0]   b_dout
);

  localparam int NB      = DATA_W / 8;
  localparam int NL      = DATA_W / LANE_W;
  localparam int LB      = LANE_W / 8;
  localparam int IDX_LSB = $clog2(NB);
  localparam int IDX_W   = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  a_idx, b_idx;
  logic              b_wr, b_acc_req;
  logic              acc_v;
  logic [IDX_W-1:0]  acc_idx;
  logic [NB-1:0]     acc_we;
  logic [DATA_W-1:0] acc_din;
  logic [DATA_W-1:0] acc_merged, b_fwd;
  logic [DATA_W-1:0] a_rd, b_rd, a_q, b_q;
  logic              unused_addr;

  assign a_idx       = a_addr[IDX_LSB +: IDX_W];
  assign b_idx       = b_addr[IDX_LSB +: IDX_W];
  assign unused_addr = ^{a_addr, b_addr};

  assign b_wr      = b_en && !b_acc && (b_we != '0);
  assign b_acc_req = b_en && b_acc && (b_we != '0);

  function automatic logic lane_gt(input logic [LANE_W-1:0] x, input logic [LANE_W-1:0] y);
    if (LANE_SIGNED) return $signed(x) > $signed(y);
    else             return x > y;
  endfunction

  // Stage 1: b_rd holds the forwarded operand captured at the request edge.
  always_comb begin
    acc_merged = b_rd;
    for (int l = 0; l < NL; l++) begin
      if (&acc_we[l*LB +: LB]) begin
        if (lane_gt(acc_din[l*LANE_W +: LANE_W], b_rd[l*LANE_W +: LANE_W]))
          acc_merged[l*LANE_W +: LANE_W] = acc_din[l*LANE_W +: LANE_W];
      end
    end
  end

  // Operand for a new accumulate is the word as it stands after this edge's commits.
  // A pending B commit overrides A on the bytes both ports write.
  always_comb begin
    b_fwd = mem[b_idx];
    for (int i = 0; i < NB; i++) begin
      if (acc_v && (acc_idx == b_idx) && acc_we[i])
        b_fwd[i*8 +: 8] = acc_merged[i*8 +: 8];
      else if (a_en && a_we[i] && (a_idx == b_idx))
        b_fwd[i*8 +: 8] = a_din[i*8 +: 8];
    end
  end

  // Later assignments win: B's commit or plain write overrides A on shared bytes.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (a_en && a_we[i])
        mem[a_idx][i*8 +: 8] <= a_din[i*8 +: 8];
      if (acc_v && acc_we[i])
        mem[acc_idx][i*8 +: 8] <= acc_merged[i*8 +: 8];
      if (b_wr && b_we[i])
        mem[b_idx][i*8 +: 8] <= b_din[i*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rd    <= '0;
      b_rd    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_v   <= 1'b0;
      acc_idx <= '0;
      acc_we  <= '0;
      acc_din <= '0;
    end else begin
      if (a_en) a_rd <= mem[a_idx];
      if (b_acc_req)  b_rd <= b_fwd;
      else if (b_en)  b_rd <= mem[b_idx];
      a_q   <= a_rd;
      b_q   <= b_rd;
      acc_v <= b_acc_req;
      if (b_acc_req) begin
        acc_idx <= b_idx;
        acc_we  <= b_we;
        acc_din <= b_din;
      end
    end
  end

  assign a_dout = OUT_REG ? a_q : a_rd;
  assign b_dout = OUT_REG ? b_q : b_rd;

endmodule
